// File: rtl/mem_interface_unit_pkg.sv
// Shared definitions for the memory interface unit: access sizes, RW encoding, FSM states
// and the alignment / load-extension helpers used by the datapath.
package mem_interface_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_RSVD  = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Half needs an even address, word a multiple of four; the reserved size always faults.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = off[0];
      SZ_WORD: f = |off;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // raw carries the loaded value right-justified; upper bits are zero or sign filled.
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                              input logic sgn);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_interface_unit_ram.sv
// Byte-addressable RAM organised as four byte lanes behind a word-aligned port.
// Lane 3 (bits 31:24) holds the lowest byte address of each word (big-endian).
module ram_byte_array
  import mem_interface_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic [ADDR_W-3:0] word_addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem_q [WORDS];

    // Synchronous per-lane write; contents are not reset.
    always_ff @(posedge clk_i) begin
      if (be_i[g]) begin
        mem_q[word_addr_i] <= wdata_i[8*g +: 8];
      end
    end

    assign rdata_o[8*g +: 8] = mem_q[word_addr_i];
  end

endmodule

// File: rtl/mem_interface_unit.sv
// Memory interface: MAR/MDR, wait-state timer and handshake FSM in front of a byte RAM.
// Handles byte/half/word big-endian access, load extension and alignment faults.
module mem_interface_unit
  import mem_interface_unit_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MAR_LD,
  input  logic              MDR_LD,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic              SIGNED,
  input  logic [31:0]       BUS_IN,
  output logic [ADDR_W-1:0] MAR_Q,
  output logic [31:0]       MDR_Q,
  output logic              MOC,
  output logic              FAULT
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              fault_q, fault_d;
  logic              moc_q, moc_d;

  logic [1:0]        byte_off_s;
  logic [4:0]        shamt_s;
  logic [31:0]       shifted_s;
  logic [31:0]       rdata_s;
  logic [31:0]       raw_s;
  logic [31:0]       lane_wdata_s;
  logic [3:0]        lane_be_s;
  logic [3:0]        ram_be_s;
  logic [3:0]        ram_we_s;
  logic              fault_s;

  assign byte_off_s = mar_q[1:0];
  assign fault_s    = access_fault(size_q, byte_off_s);
  assign shamt_s    = {2'd3 - byte_off_s, 3'b000};
  assign shifted_s  = rdata_s >> shamt_s;

  ram_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i      (CLK),
    .word_addr_i(mar_q[ADDR_W-1:2]),
    .be_i       (ram_we_s),
    .wdata_i    (lane_wdata_s),
    .rdata_o    (rdata_s)
  );

  // Steer MDR onto the byte lanes for writes and pick the addressed bytes for reads.
  always_comb begin
    lane_be_s    = 4'b0000;
    lane_wdata_s = mdr_q;
    raw_s        = rdata_s;
    case (size_q)
      SZ_BYTE: begin
        lane_be_s    = 4'b1000 >> byte_off_s;
        lane_wdata_s = {4{mdr_q[7:0]}};
        raw_s        = {24'h000000, shifted_s[7:0]};
      end
      SZ_HALF: begin
        lane_be_s    = byte_off_s[1] ? 4'b0011 : 4'b1100;
        lane_wdata_s = {2{mdr_q[15:0]}};
        raw_s        = {16'h0000, (byte_off_s[1] ? rdata_s[15:0] : rdata_s[31:16])};
      end
      SZ_WORD: begin
        lane_be_s    = 4'b1111;
        lane_wdata_s = mdr_q;
        raw_s        = rdata_s;
      end
      default: begin
        lane_be_s    = 4'b0000;
        lane_wdata_s = mdr_q;
        raw_s        = rdata_s;
      end
    endcase
  end

  // Handshake FSM, wait timer and MAR/MDR next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    rw_d     = rw_q;
    size_d   = size_q;
    signed_d = signed_q;
    fault_d  = fault_q;
    ram_be_s = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        fault_d = 1'b0;
        if (MAR_LD) begin
          mar_d = BUS_IN[ADDR_W-1:0];
        end else begin
          mar_d = mar_q;
        end
        if (MDR_LD) begin
          mdr_d = BUS_IN;
        end else begin
          mdr_d = mdr_q;
        end
        if (MOV) begin
          rw_d     = RW;
          size_d   = SIZE;
          signed_d = SIGNED;
          cnt_d    = 4'(WAIT_CYCLES);
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!MOV) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          fault_d = fault_s;
          if (fault_s) begin
            ram_be_s = 4'b0000;
          end else if (rw_q == RW_READ) begin
            mdr_d = load_extend(raw_s, size_q, signed_q);
          end else begin
            ram_be_s = lane_be_s;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // MOV held here never restarts an access; only release returns to IDLE.
        if (!MOV) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    moc_d    = (state_d == ST_DONE);
    ram_we_s = RESET_N ? ram_be_s : 4'b0000;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      mar_q    <= '0;
      mdr_q    <= 32'h0000_0000;
      rw_q     <= RW_WRITE;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      moc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      fault_q  <= fault_d;
      moc_q    <= moc_d;
    end
  end

  assign MAR_Q = mar_q;
  assign MDR_Q = mdr_q;
  assign MOC   = moc_q;
  assign FAULT = fault_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Self-checking bench for mem_interface_unit: directed table, multi-cycle corner sequences,
// and randomized accesses compared against a byte-array reference model.
module tb_mem_interface_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mar_ld, mdr_ld, mov, rw, sgn;
  logic [1:0]  size;
  logic [31:0] bus;
  logic [7:0]  mar_q;
  logic [31:0] mdr_q;
  logic        moc, fault;

  logic        z_rst_n, z_mar_ld, z_mdr_ld, z_mov, z_rw, z_sgn;
  logic [1:0]  z_size;
  logic [31:0] z_bus;
  logic [7:0]  z_mar_q;
  logic [31:0] z_mdr_q;
  logic        z_moc, z_fault;

  mem_interface_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .RESET_N(rst_n), .MAR_LD(mar_ld), .MDR_LD(mdr_ld), .MOV(mov), .RW(rw),
    .SIZE(size), .SIGNED(sgn), .BUS_IN(bus), .MAR_Q(mar_q), .MDR_Q(mdr_q), .MOC(moc),
    .FAULT(fault)
  );

  mem_interface_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RESET_N(z_rst_n), .MAR_LD(z_mar_ld), .MDR_LD(z_mdr_ld), .MOV(z_mov), .RW(z_rw),
    .SIZE(z_size), .SIGNED(z_sgn), .BUS_IN(z_bus), .MAR_Q(z_mar_q), .MDR_Q(z_mdr_q),
    .MOC(z_moc), .FAULT(z_fault)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ref_mem [256];

  typedef struct {
    string       name;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_mdr;
    logic        exp_fault;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: big-endian byte memory, size = 1 << SIZE bytes, fault by alignment rules.
  task automatic model(input logic r, input logic [1:0] sz, input logic s, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] exp_mdr,
                       output logic exp_fault);
    int n;
    logic [31:0] v;
    exp_fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_mdr   = wd;
    if (!exp_fault) begin
      n = 1 << sz;
      if (r) begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a + 8'(i)]);
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_mdr = v;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[a + 8'(i)] = 8'(wd >> (8 * (n - 1 - i)));
      end
    end
  endtask

  // Full transaction on the W=2 instance: load MAR and MDR, assert MOV, wait for MOC, release.
  task automatic access(input string name, input logic r, input logic [1:0] sz, input logic s,
                        input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] got_mdr, output logic got_fault);
    int lat;
    mar_ld = 1'b1; bus = {24'h0, a}; tick;
    mar_ld = 1'b0; mdr_ld = 1'b1; bus = wd; tick;
    mdr_ld = 1'b0; bus = 32'h0;
    mov = 1'b1; rw = r; size = sz; sgn = s; tick;
    lat = 0;
    while (!moc && lat < 40) begin
      tick;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    got_mdr   = mdr_q;
    got_fault = fault;
    mov = 1'b0; tick;
    check({name, "_moc_release"}, {31'b0, moc}, 32'h0);
  endtask

  initial begin
    logic [31:0] got, em, wd;
    logic        gf, ef, r, s, seen;
    logic [1:0]  sz;
    logic [7:0]  a;
    int          cnt;

    rst_n = 1'b0; mar_ld = 1'b0; mdr_ld = 1'b0; mov = 1'b0; rw = 1'b0; sgn = 1'b0;
    size = 2'b00; bus = 32'h0;
    z_rst_n = 1'b0; z_mar_ld = 1'b0; z_mdr_ld = 1'b0; z_mov = 1'b0; z_rw = 1'b0; z_sgn = 1'b0;
    z_size = 2'b00; z_bus = 32'h0;
    tick; tick;
    rst_n = 1'b1; z_rst_n = 1'b1;
    check("reset_mar", {24'h0, mar_q}, 32'h0);
    check("reset_mdr", mdr_q, 32'h0);
    check("reset_moc_fault", {30'b0, moc, fault}, 32'h0);

    // Fill RAM with known data so every later read has a defined expectation.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model(1'b0, 2'b10, 1'b0, 8'(w * 4), wd, em, ef);
      access("fill", 1'b0, 2'b10, 1'b0, 8'(w * 4), wd, got, gf);
      check("fill_fault", {31'b0, gf}, {31'b0, ef});
    end

    tbl[0]  = '{"wr_word",      1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{"rd_word",      1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{"rd_byte_msb",  1'b1, 2'b00, 1'b0, 8'h10, 32'h12345678, 32'h000000DE, 1'b0};
    tbl[3]  = '{"rd_byte_zx",   1'b1, 2'b00, 1'b0, 8'h13, 32'h12345678, 32'h000000EF, 1'b0};
    tbl[4]  = '{"rd_byte_sx",   1'b1, 2'b00, 1'b1, 8'h13, 32'h12345678, 32'hFFFFFFEF, 1'b0};
    tbl[5]  = '{"rd_half_sx",   1'b1, 2'b01, 1'b1, 8'h10, 32'h12345678, 32'hFFFFDEAD, 1'b0};
    tbl[6]  = '{"wr_byte",      1'b0, 2'b00, 1'b0, 8'h11, 32'h00000055, 32'h00000055, 1'b0};
    tbl[7]  = '{"rd_after_byte",1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678, 32'hDE55BEEF, 1'b0};
    tbl[8]  = '{"mis_word_rd",  1'b1, 2'b10, 1'b0, 8'h12, 32'h12345678, 32'h12345678, 1'b1};
    tbl[9]  = '{"mis_half_rd",  1'b1, 2'b01, 1'b0, 8'h11, 32'h12345678, 32'h12345678, 1'b1};
    tbl[10] = '{"mis_word_wr",  1'b0, 2'b10, 1'b0, 8'h12, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1};
    tbl[11] = '{"rsvd_size",    1'b1, 2'b11, 1'b0, 8'h10, 32'h0BADF00D, 32'h0BADF00D, 1'b1};
    tbl[12] = '{"rd_unchanged", 1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678, 32'hDE55BEEF, 1'b0};

    for (int i = 0; i < 13; i++) begin
      model(tbl[i].rw, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, em, ef);
      access(tbl[i].name, tbl[i].rw, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, got, gf);
      check({tbl[i].name, "_mdr"}, got, tbl[i].exp_mdr);
      check({tbl[i].name, "_fault"}, {31'b0, gf}, {31'b0, tbl[i].exp_fault});
    end

    // Abort: write to 0x20 dropped while waiting; MOC must never rise and RAM stays intact.
    mar_ld = 1'b1; bus = 32'h20; tick;
    mar_ld = 1'b0; mdr_ld = 1'b1; bus = 32'h11223344; tick;
    mdr_ld = 1'b0; mov = 1'b1; rw = 1'b0; size = 2'b10; tick; tick;
    mov = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | moc;
    end
    check("abort_no_moc", {31'b0, seen}, 32'h0);
    model(1'b1, 2'b10, 1'b0, 8'h20, 32'h0, em, ef);
    access("abort_readback", 1'b1, 2'b10, 1'b0, 8'h20, 32'h0, got, gf);
    check("abort_readback_mdr", got, em);

    // Reset while in DONE clears MOC, MAR and MDR at the next edge.
    mar_ld = 1'b1; bus = 32'h10; tick;
    mar_ld = 1'b0; mov = 1'b1; rw = 1'b1; size = 2'b10; tick;
    cnt = 0;
    while (!moc && cnt < 40) begin
      tick;
      cnt++;
    end
    check("done_reached", {31'b0, moc}, 32'h1);
    rst_n = 1'b0; tick;
    check("rst_done_moc", {31'b0, moc}, 32'h0);
    check("rst_done_mar", {24'h0, mar_q}, 32'h0);
    check("rst_done_mdr", mdr_q, 32'h0);
    rst_n = 1'b1; mov = 1'b0; tick;

    // Reset on the edge where a write would land must suppress it.
    mar_ld = 1'b1; bus = 32'h30; tick;
    mar_ld = 1'b0; mdr_ld = 1'b1; bus = 32'hCAFEF00D; tick;
    mdr_ld = 1'b0; mov = 1'b1; rw = 1'b0; size = 2'b10; tick; tick; tick;
    rst_n = 1'b0; tick;
    check("rst_wait_moc", {31'b0, moc}, 32'h0);
    rst_n = 1'b1; mov = 1'b0; tick;
    model(1'b1, 2'b10, 1'b0, 8'h30, 32'h0, em, ef);
    access("rst_wait_readback", 1'b1, 2'b10, 1'b0, 8'h30, 32'h0, got, gf);
    check("rst_wait_readback_mdr", got, em);

    // Randomized accesses, mostly aligned, checked against the reference model.
    for (int i = 0; i < 150; i++) begin
      r  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~(8'((1 << sz) - 1));
      model(r, sz, s, a, wd, em, ef);
      access("rand", r, sz, s, a, wd, got, gf);
      check("rand_mdr", got, em);
      check("rand_fault", {31'b0, gf}, {31'b0, ef});
    end

    // Zero-wait instance: one-cycle MOC, MOV held in DONE gives one access, MAR_LD ignored.
    check("w0_reset_mar", {24'h0, z_mar_q}, 32'h0);
    check("w0_reset_moc", {31'b0, z_moc}, 32'h0);
    z_mar_ld = 1'b1; z_bus = 32'h04; tick;
    z_mar_ld = 1'b0; z_mdr_ld = 1'b1; z_bus = 32'h01020304; tick;
    z_mdr_ld = 1'b0; z_mov = 1'b1; z_rw = 1'b0; z_size = 2'b10; tick;
    check("w0_moc_early", {31'b0, z_moc}, 32'h0);
    tick;
    check("w0_latency", {31'b0, z_moc}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      z_mar_ld = (i == 0); z_bus = 32'hFF;
      tick;
      if (z_moc) cnt++;
    end
    z_mar_ld = 1'b0;
    check("w0_hold_moc", 32'(cnt), 32'd5);
    check("w0_mar_ignored", {24'h0, z_mar_q}, 32'h04);
    z_mov = 1'b0; tick;
    check("w0_release", {31'b0, z_moc}, 32'h0);
    z_mdr_ld = 1'b1; z_bus = 32'h0; tick;
    z_mdr_ld = 1'b0; z_mov = 1'b1; z_rw = 1'b1; tick; tick;
    check("w0_read_moc", {31'b0, z_moc}, 32'h1);
    check("w0_read_mdr", z_mdr_q, 32'h01020304);
    z_mov = 1'b0; tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
